// File: rtl/reg_file_dump.sv
// reg_file_dump
//   2^ADDR_WIDTH x DATA_WIDTH register file for the ALU: two combinational
//   read ports (OUT1/OUT2 -> DATA1/DATA2) and one synchronous write port
//   (IN <- ALU RESULT). A debug port snapshots every register into a shadow
//   buffer on DUMP_REQ and streams the copy out over a valid/ready handshake,
//   so live writes during the dump never disturb the streamed image.
//   Optional build macro: REGFILE_BYPASS_EN -- when defined, a write to the
//   address being read is forwarded combinationally to that read port in the
//   same cycle. The dump logic is identical in both builds.
module reg_file_dump #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] IN,
   input  logic [ADDR_WIDTH-1:0] INADDRESS,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
   input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
   output logic [DATA_WIDTH-1:0] OUT1,
   output logic [DATA_WIDTH-1:0] OUT2,
   input  logic                  DUMP_REQ,
   input  logic                  DUMP_READY,
   output logic                  DUMP_VALID,
   output logic [DATA_WIDTH-1:0] DUMP_DATA,
   output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
   output logic                  DUMP_BUSY,
   output logic                  DUMP_DONE
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [DATA_WIDTH-1:0] r_regs   [NUM_REGS];
   logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
   logic [ADDR_WIDTH-1:0] r_ptr;

   logic                  w_snap;
   logic                  w_xfer;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_rd1;
   logic [DATA_WIDTH-1:0] w_rd2;

   // Snapshot is taken only from IDLE; a transfer only happens while streaming.
   assign w_snap = (r_state == ST_IDLE) && DUMP_REQ;
   assign w_xfer = (r_state == ST_STREAM) && DUMP_READY;
   assign w_last = (r_ptr == LAST_IDX);

   // Live register array: async clear, single synchronous write port
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (WRITE) begin
         r_regs[INADDRESS] <= IN;
      end
   end

   // Shadow buffer: whole-file copy of the pre-write register values
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_shadow[i] <= '0;
         end
      end else if (w_snap) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_shadow[i] <= r_regs[i];
         end
      end
   end

   // Stream pointer: restarts on snapshot, advances per accepted beat, and
   // wraps naturally to 0 after the last index
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_ptr <= '0;
      end else if (w_snap) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   // Dump FSM state register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Dump FSM next-state logic; REQ is only looked at in IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (DUMP_REQ) begin
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (DUMP_READY && w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Dump FSM outputs; data/addr come straight from the shadow so they stay
   // stable while READY is low
   always_comb begin
      DUMP_VALID = 1'b0;
      DUMP_BUSY  = 1'b0;
      DUMP_DONE  = 1'b0;
      DUMP_DATA  = '0;
      DUMP_ADDR  = '0;
      case (r_state)
         ST_STREAM: begin
            DUMP_VALID = 1'b1;
            DUMP_BUSY  = 1'b1;
            DUMP_DATA  = r_shadow[r_ptr];
            DUMP_ADDR  = r_ptr;
         end
         ST_DONE: begin
            DUMP_BUSY  = 1'b1;
            DUMP_DONE  = 1'b1;
         end
         default: begin
            DUMP_VALID = 1'b0;
         end
      endcase
   end

   // Read port 1: stored value, optionally forwarded from the write port
   always_comb begin
      w_rd1 = r_regs[OUT1ADDRESS];
`ifdef REGFILE_BYPASS_EN
      if (WRITE && (OUT1ADDRESS == INADDRESS)) begin
         w_rd1 = IN;
      end
`else
      w_rd1 = r_regs[OUT1ADDRESS];
`endif
   end

   // Read port 2: stored value, optionally forwarded from the write port
   always_comb begin
      w_rd2 = r_regs[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
      if (WRITE && (OUT2ADDRESS == INADDRESS)) begin
         w_rd2 = IN;
      end
`else
      w_rd2 = r_regs[OUT2ADDRESS];
`endif
   end

   assign OUT1 = w_rd1;
   assign OUT2 = w_rd2;

endmodule

// File: doc/reg_file_dump.md
Name: reg_file_dump

Overview:
- Register file feeding the ALU operand inputs DATA1/DATA2.
- Provides 2^ADDR_WIDTH general registers, two combinational read ports and one synchronous write port; the write port takes RESULT from the ALU.
- Adds a snapshot-and-stream debug port: on request it copies all registers into a shadow buffer and streams them out over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, width of each register and data port.
- ADDR_WIDTH, 3, register address width; NUM_REGS = 2^ADDR_WIDTH (8).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- IN  input  DATA_WIDTH  write data (ALU RESULT).
- INADDRESS  input  ADDR_WIDTH  write register index.
- WRITE  input  1  write enable.
- OUT1ADDRESS  input  ADDR_WIDTH  read port 1 index.
- OUT2ADDRESS  input  ADDR_WIDTH  read port 2 index.
- OUT1  output  DATA_WIDTH  read port 1 data (to ALU DATA1).
- OUT2  output  DATA_WIDTH  read port 2 data (to ALU DATA2).
- DUMP_REQ  input  1  start snapshot/stream.
- DUMP_READY  input  1  consumer accepts DUMP_DATA.
- DUMP_VALID  output  1  DUMP_DATA/DUMP_ADDR valid.
- DUMP_DATA  output  DATA_WIDTH  streamed register value.
- DUMP_ADDR  output  ADDR_WIDTH  index of streamed value.
- DUMP_BUSY  output  1  dump in progress.
- DUMP_DONE  output  1  one-cycle pulse after last transfer.

Behaviour:
- Reset (RESET low, async): all registers, shadow buffer and pointer cleared to 0; FSM to IDLE; DUMP_VALID, DUMP_BUSY and DUMP_DONE are 0. OUT1/OUT2 therefore read 0. Reset mid-dump aborts the dump with no DONE pulse.
- Read ports: purely combinational; OUTx = reg[OUTxADDRESS]; zero latency. The same address may be read on both ports.
- Write: on rising CLK with WRITE=1, reg[INADDRESS] <= IN; the new value is visible on reads after that edge. WRITE=0 leaves registers unchanged. No register is hard-wired.
- FSM states: IDLE, STREAM, DONE.
- IDLE: DUMP_BUSY=0, DUMP_VALID=0. When DUMP_REQ=1 at a rising edge: shadow[i] <= reg[i] for all i, pointer <= 0, go to STREAM. If WRITE is active on the same edge, the snapshot captures the pre-write value.
- STREAM: DUMP_BUSY=1, DUMP_VALID=1, DUMP_DATA=shadow[pointer], DUMP_ADDR=pointer.
  - On VALID&&READY: if pointer==NUM_REGS-1, go to DONE; otherwise pointer+1.
  - READY low holds pointer and data stable. Data may not change while VALID is high without a transfer.
- DONE: DUMP_DONE=1 and DUMP_BUSY=1 for exactly one cycle, DUMP_VALID=0, then IDLE. The pointer wraps to 0.
- DUMP_REQ is ignored in STREAM and DONE; it is level-sampled only in IDLE. A REQ still held at the DONE→IDLE return starts a new dump on the next edge.
- Register writes during a dump are permitted and update the live registers only; the shadow buffer is unaffected.
- Exactly NUM_REGS transfers per dump, in ascending address order.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when WRITE=1 and OUTxADDRESS==INADDRESS, OUTx returns IN combinationally in the same cycle (write-to-read forwarding), independently per port.
- Undefined: OUTx returns the stored value until the write edge.
- Dump behaviour is identical in both builds.

Test Plan:
- Reset: RESET low mid-cycle with registers nonzero -> OUT1=OUT2=0 immediately; DUMP_VALID=0.
- Write/read: write 5→R1 and 8→R2 on consecutive edges; OUT1ADDRESS=1, OUT2ADDRESS=2 -> OUT1=5, OUT2=8; WRITE=0 with IN=99 -> values unchanged.
- Bypass: WRITE=1, INADDRESS=3, IN=42, OUT1ADDRESS=3 before the edge -> OUT1=42 with REGFILE_BYPASS_EN, old value (0) without it; both builds give 42 after the edge.
- Dump, READY tied high: registers R0..R7 = 10..17, pulse DUMP_REQ -> 8 consecutive VALID cycles with ADDR 0..7 and DATA 10..17, then DONE high for 1 cycle, BUSY low the cycle after.
- Backpressure plus concurrent write: READY toggles 1,0,0,1,...; write 77→R0 during the dump -> DATA/ADDR held stable while READY=0, R0 streams the snapshot value 10, live OUT1 for R0 reads 77; DUMP_REQ pulsed mid-dump is ignored.
- Reset mid-dump: assert RESET after the 3rd transfer -> VALID, BUSY and DONE drop immediately, no DONE pulse; a new DUMP_REQ restarts from ADDR 0 with data 0.
